// File: rtl/rom_port_arbiter.sv
// Arbitrates the single-port instruction ROM between instruction fetch (IF) and data loads (LD).
// Optional round-robin arbitration is enabled by defining ROM_ARB_RR_EN.
module rom_port_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    input  logic              if_flush,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_data,
    input  logic              ld_req_valid,
    input  logic [ADDR_W-1:0] ld_req_addr,
    output logic              ld_req_ready,
    output logic              ld_rsp_valid,
    output logic [31:0]       ld_rsp_data,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [31:0]       rom_data
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LD   = 2'd2
    } owner_e;

    owner_e            rsp_owner_q, rsp_owner_d;
    logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
    logic              if_grant, ld_grant;

`ifdef ROM_ARB_RR_EN
    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_LD = 1'b1
    } gnt_e;

    gnt_e last_grant_q, last_grant_d;
`else
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
`endif

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_owner_q  <= OWN_NONE;
            addr_hold_q  <= '0;
`ifdef ROM_ARB_RR_EN
            last_grant_q <= GNT_IF;
`else
            starve_cnt_q <= '0;
`endif
        end else begin
            rsp_owner_q  <= rsp_owner_d;
            addr_hold_q  <= addr_hold_d;
`ifdef ROM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`else
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

    // Grant selection and next-state
    always_comb begin
        if_grant    = 1'b0;
        ld_grant    = 1'b0;
        rsp_owner_d = OWN_NONE;
        addr_hold_d = addr_hold_q;
`ifdef ROM_ARB_RR_EN
        last_grant_d = last_grant_q;
`else
        starve_cnt_d = '0;
`endif

        if (!reset) begin
            if (if_req_valid && ld_req_valid) begin
`ifdef ROM_ARB_RR_EN
                if (last_grant_q == GNT_IF) ld_grant = 1'b1;
                else                        if_grant = 1'b1;
`else
                if (starve_cnt_q == CNT_W'(STARVE_MAX)) ld_grant = 1'b1;
                else                                    if_grant = 1'b1;
`endif
            end else begin
                if_grant = if_req_valid;
                ld_grant = ld_req_valid;
            end
        end

        if (if_grant) begin
            rsp_owner_d = OWN_IF;
            addr_hold_d = if_req_addr;
        end else if (ld_grant) begin
            rsp_owner_d = OWN_LD;
            addr_hold_d = ld_req_addr;
        end

        // A flush only cancels an IF word not re-launched this cycle; with single-cycle latency none remains
        if (if_flush && !if_grant && rsp_owner_d == OWN_IF) rsp_owner_d = OWN_NONE;

`ifdef ROM_ARB_RR_EN
        if (if_grant) last_grant_d = GNT_IF;
        if (ld_grant) last_grant_d = GNT_LD;
`else
        if (ld_req_valid && !ld_grant) begin
            if (starve_cnt_q != CNT_W'(STARVE_MAX)) starve_cnt_d = starve_cnt_q + CNT_W'(1);
            else                                    starve_cnt_d = starve_cnt_q;
        end
`endif
    end

    assign if_req_ready = if_grant;
    assign ld_req_ready = ld_grant;
    assign rom_address  = if_grant ? if_req_addr : (ld_grant ? ld_req_addr : addr_hold_q);

    // Route the word returned this cycle to whichever port launched it
    assign if_rsp_valid = (rsp_owner_q == OWN_IF);
    assign ld_rsp_valid = (rsp_owner_q == OWN_LD);
    assign if_rsp_data  = if_rsp_valid ? rom_data : 32'h0;
    assign ld_rsp_data  = ld_rsp_valid ? rom_data : 32'h0;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Randomized and directed bench for rom_port_arbiter with a transaction-level reference model.
// Honours ROM_ARB_RR_EN the same way the design does.
module tb_rom_port_arbiter;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned STARVE_MAX = 4;

    logic              clk;
    logic              reset;
    logic              if_req_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_req_ready;
    logic              if_flush;
    logic              if_rsp_valid;
    logic [31:0]       if_rsp_data;
    logic              ld_req_valid;
    logic [ADDR_W-1:0] ld_req_addr;
    logic              ld_req_ready;
    logic              ld_rsp_valid;
    logic [31:0]       ld_rsp_data;
    logic [ADDR_W-1:0] rom_address;
    logic [31:0]       rom_data;

    int n_cmp = 0;
    int n_err = 0;

    rom_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_ready(ld_req_ready),
        .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data),
        .rom_address(rom_address), .rom_data(rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [ADDR_W-1:0] a);
        return 32'hF00D_0000 | 32'(a[ADDR_W-1:2]);
    endfunction

    // ROM: one-cycle read latency, word addressed
    always @(posedge clk) rom_data <= rom_word(rom_address);

    // Reference model state: who gets the word next cycle, and the arbitration history
    int                m_owner;      // 0 none, 1 IF, 2 LD
    logic [ADDR_W-1:0] m_rsp_addr;
    logic [ADDR_W-1:0] m_hold;
    int                m_wait;       // cycles LD has been left waiting in a row
    bit                m_last_ld;    // most recent winner was LD
    bit                exp_gi, exp_gl;

    task automatic model_reset();
        m_owner = 0; m_rsp_addr = '0; m_hold = '0; m_wait = 0; m_last_ld = 1'b0;
        exp_gi = 1'b0; exp_gl = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare all outputs for the current cycle, then advance the model over the coming edge
    task automatic model_check();
        bit gi, gl;
        logic [ADDR_W-1:0] ea;
        chk("if_rsp_valid", 32'(if_rsp_valid), 32'(m_owner == 1));
        chk("ld_rsp_valid", 32'(ld_rsp_valid), 32'(m_owner == 2));
        chk("if_rsp_data", if_rsp_data, (m_owner == 1) ? rom_word(m_rsp_addr) : 32'h0);
        chk("ld_rsp_data", ld_rsp_data, (m_owner == 2) ? rom_word(m_rsp_addr) : 32'h0);

        if (if_req_valid && ld_req_valid) begin
`ifdef ROM_ARB_RR_EN
            gl = !m_last_ld;
`else
            gl = (m_wait >= int'(STARVE_MAX));
`endif
            gi = !gl;
        end else begin
            gi = if_req_valid;
            gl = ld_req_valid;
        end
        ea = gi ? if_req_addr : (gl ? ld_req_addr : m_hold);
        chk("if_req_ready", 32'(if_req_ready), 32'(gi));
        chk("ld_req_ready", 32'(ld_req_ready), 32'(gl));
        chk("rom_address", 32'(rom_address), 32'(ea));

        // Flush never removes a word launched this same cycle, so only the grant decides ownership
        m_owner = gi ? 1 : (gl ? 2 : 0);
        if (gi || gl) begin
            m_rsp_addr = ea;
            m_hold     = ea;
        end
        if (ld_req_valid && !gl) m_wait = (m_wait + 1 > int'(STARVE_MAX)) ? int'(STARVE_MAX) : m_wait + 1;
        else                     m_wait = 0;
        if (gi) m_last_ld = 1'b0;
        if (gl) m_last_ld = 1'b1;
        exp_gi = gi;
        exp_gl = gl;
    endtask

    task automatic cycle(input logic iv, input logic [ADDR_W-1:0] ia,
                         input logic lv, input logic [ADDR_W-1:0] la, input logic fl);
        @(posedge clk);
        #1;
        if_req_valid = iv; if_req_addr = ia;
        ld_req_valid = lv; ld_req_addr = la;
        if_flush     = fl;
        @(negedge clk);
        model_check();
    endtask

    initial begin
        logic [ADDR_W-1:0] ia, la;
        bit ip, lp, prev_ld, exp_ld;

        reset = 1'b1;
        if_req_valid = 1'b0; if_req_addr = '0;
        ld_req_valid = 1'b0; ld_req_addr = '0;
        if_flush = 1'b0;
        model_reset();
        #2;
        chk("reset_if_ready", 32'(if_req_ready), 32'h0);
        chk("reset_if_rsp_valid", 32'(if_rsp_valid), 32'h0);
        chk("reset_ld_rsp_data", ld_rsp_data, 32'h0);
        chk("reset_rom_address", 32'(rom_address), 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // IF only, back-to-back
        cycle(1'b1, 16'h0000, 1'b0, 16'h0, 1'b0);
        chk("ifonly_ready0", 32'(if_req_ready), 32'h1);
        chk("ifonly_addr0", 32'(rom_address), 32'h0000);
        cycle(1'b1, 16'h0004, 1'b0, 16'h0, 1'b0);
        chk("ifonly_rsp0", if_rsp_data, 32'hF00D_0000);
        cycle(1'b1, 16'h0008, 1'b0, 16'h0, 1'b0);
        chk("ifonly_rsp1", if_rsp_data, 32'hF00D_0001);
        cycle(1'b0, 16'h0000, 1'b0, 16'h0, 1'b0);
        chk("ifonly_rsp2", if_rsp_data, 32'hF00D_0002);
        chk("ifonly_ld_valid", 32'(ld_rsp_valid), 32'h0);
        chk("ifonly_hold_addr", 32'(rom_address), 32'h0008);

        // Continuous contention, LD parked on 0x0100
        ia = 16'h0200;
        prev_ld = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, ia, 1'b1, 16'h0100, 1'b0);
`ifdef ROM_ARB_RR_EN
            exp_ld = (k % 2 == 0);
`else
            exp_ld = (k == 4) || (k == 9);
`endif
            chk("contend_ld_ready", 32'(ld_req_ready), 32'(exp_ld));
            if (prev_ld) chk("contend_ld_word", ld_rsp_data, 32'hF00D_0040);
            if (exp_gi) ia = ia + 16'h4;
            prev_ld = exp_ld;
        end
        cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);

        // Flush with IF idle after a grant, then flush coinciding with a new IF grant
        cycle(1'b1, 16'h0010, 1'b0, 16'h0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 16'h0, 1'b1);
        chk("flush_prev_word", if_rsp_data, 32'hF00D_0004);
        cycle(1'b0, 16'h0000, 1'b0, 16'h0, 1'b0);
        chk("flush_idle_no_pulse", 32'(if_rsp_valid), 32'h0);
        cycle(1'b1, 16'h0020, 1'b0, 16'h0, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0, 16'h0, 1'b0);
        chk("flush_grant_pulse", 32'(if_rsp_valid), 32'h1);
        chk("flush_grant_word", if_rsp_data, 32'hF00D_0008);

        // Misaligned byte address
        cycle(1'b1, 16'h0013, 1'b0, 16'h0, 1'b0);
        chk("misalign_addr", 32'(rom_address), 32'h0013);
        cycle(1'b0, 16'h0000, 1'b0, 16'h0, 1'b0);
        chk("misalign_word", if_rsp_data, 32'hF00D_0004);

        // Reset while IF is being granted
        cycle(1'b1, 16'h0030, 1'b0, 16'h0, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_if_ready", 32'(if_req_ready), 32'h0);
        chk("midrst_ld_ready", 32'(ld_req_ready), 32'h0);
        chk("midrst_rom_address", 32'(rom_address), 32'h0);
        if_req_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        cycle(1'b0, 16'h0000, 1'b0, 16'h0, 1'b0);
        chk("postrst_no_pulse", 32'(if_rsp_valid), 32'h0);
        chk("postrst_rom_address", 32'(rom_address), 32'h0);

        // Random traffic; requests stay stable until accepted
        ip = 1'b0; lp = 1'b0; ia = '0; la = '0;
        for (int n = 0; n < 2000; n++) begin
            if (!ip && $urandom_range(0, 9) < 6) begin ip = 1'b1; ia = ADDR_W'($urandom); end
            if (!lp && $urandom_range(0, 9) < 5) begin lp = 1'b1; la = ADDR_W'($urandom); end
            cycle(ip, ia, lp, la, 1'($urandom_range(0, 3) == 0));
            if (exp_gi) ip = 1'b0;
            if (exp_gl) lp = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
